// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   PAR_EN_BIT / PAR_ODD_BIT : bit positions inside the 2-bit parity control word
//   uart_state_e             : frame-level state encoding
//   clog2                    : counter width helper (never returns less than 1)
package uart_pkg;

    localparam int unsigned PAR_EN_BIT  = 0;
    localparam int unsigned PAR_ODD_BIT = 1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    // Bits needed to hold the values 0..n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the UART register block and the transmitter.
//   tx_data       : byte to send
//   tx_data_valid : request to send tx_data
//   tx_ctrl       : parity control {odd, enable}
//   tx_ready      : transmitter can accept; transfer on valid & ready at a rising edge
// master drives the request side, slave is the transmitter.
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic [1:0] tx_ctrl;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        output tx_ctrl,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        input  tx_ctrl,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and flags the last clock of each bit.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : hold the counter at 0 (no tick while asserted)
//   tick     : high during the last clock of every DIV-clock bit period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    CntW   = clog2(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = !clear && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : byte handshake (slave side), data and parity control sampled on acceptance
//   tx       : serial line, idle high, driven straight from a flop
//   tx_done  : one-cycle pulse in the clock following the final stop-bit clock
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BODE_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       tx_done
);

    localparam int unsigned DIV = CLK_FREQ / BODE_RATE;

    if (DIV < 2) begin : gen_div_check
        $error("uart_tx: CLK_FREQ / BODE_RATE must be at least 2");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        parity_q, parity_d;
    logic        par_en_q, par_en_d;
    logic        tx_q, tx_d;
    logic        tx_done_q, tx_done_d;

    logic tick;
    logic ready;
    logic accept;

    // Counter idles at 0 so the start bit always gets a full DIV clocks.
    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

    // Ready in the last stop clock lets a new frame follow with no idle gap.
    assign ready        = (state_q == StIdle) || ((state_q == StStop) && tick);
    assign accept       = ready && bus.tx_data_valid;
    assign bus.tx_ready = ready;
    assign tx           = tx_q;
    assign tx_done      = tx_done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        par_en_d  = par_en_q;
        tx_done_d = 1'b0;

        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    tx_done_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Acceptance overrides the IDLE hold and the STOP -> IDLE return.
        if (accept) begin
            shift_d   = bus.tx_data;
            parity_d  = (^bus.tx_data) ^ bus.tx_ctrl[PAR_ODD_BIT];
            par_en_d  = bus.tx_ctrl[PAR_EN_BIT];
            bit_idx_d = 3'd0;
            state_d   = StStart;
        end
    end

    // Line level is computed from the next state so tx changes exactly on bit edges.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            par_en_q  <= par_en_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx with DIV = 10 (100 MHz clock, 10 Mbit/s line).
module tb_uart_tx;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic tx_done;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_if bus ();

    uart_tx #(
        .CLK_FREQ  (100_000_000),
        .BODE_RATE (10_000_000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tx      (tx),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Caller leaves valid/data/ctrl driven so the next rising edge accepts (d, c).
    // Checks every clock of the frame against the line-level frame picture, plus a
    // mid-bit sampling receiver. chain_out keeps valid high with (nd, nc) so the next
    // frame is accepted in the last stop clock; disturb scrambles inputs while busy.
    task automatic frame(input logic [7:0] d, input logic [1:0] c, input bit chained_in,
                         input bit chain_out, input logic [7:0] nd, input logic [1:0] nc,
                         input bit disturb);
        logic [10:0] bits;
        logic [7:0]  rx_byte;
        int          nbits;
        int          f;
        nbits = c[0] ? 11 : 10;
        f     = nbits * DIV;
        bits  = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (c[0]) bits[9] = (($countones(d) + int'(c[1])) % 2) == 1;
        rx_byte = '0;

        @(posedge clk); #1;
        if (chain_out) begin
            bus.tx_data = nd;
            bus.tx_ctrl = nc;
        end else begin
            bus.tx_data_valid = 1'b0;
        end
        for (int j = 0; j < f; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            chk1($sformatf("tx d=%02h c=%0d cyc%0d", d, c, j), tx, bits[j/DIV]);
            chk1($sformatf("ready d=%02h cyc%0d", d, j), bus.tx_ready, j == f - 1);
            chk1($sformatf("done d=%02h cyc%0d", d, j), tx_done, chained_in && j == 0);
            if (j % DIV == DIV / 2 && j / DIV >= 1 && j / DIV <= 8) rx_byte[j/DIV-1] = tx;
            if (disturb && !chain_out) begin
                bus.tx_data       = 8'($urandom);
                bus.tx_ctrl       = 2'($urandom);
                bus.tx_data_valid = (j < f - 1) && ($urandom % 4 == 0);
            end
        end
        chk8($sformatf("loopback d=%02h", d), rx_byte, d);
        if (!chain_out) begin
            @(posedge clk); #1;
            chk1("post tx", tx, 1'b1);
            chk1("post ready", bus.tx_ready, 1'b1);
            chk1("post done pulse", tx_done, 1'b1);
            @(posedge clk); #1;
            chk1("post2 tx", tx, 1'b1);
            chk1("post2 done low", tx_done, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] d, nd;
        logic [1:0] c, nc;
        bit         chained, chain_out;

        bus.tx_data       = 8'h00;
        bus.tx_ctrl       = 2'b00;
        bus.tx_data_valid = 1'b0;

        // 1. Reset
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst tx", tx, 1'b1);
        chk1("rst ready", bus.tx_ready, 1'b1);
        chk1("rst done", tx_done, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("idle tx", tx, 1'b1);
        chk1("idle ready", bus.tx_ready, 1'b1);
        chk1("idle done", tx_done, 1'b0);

        // 2-4. Directed frames
        bus.tx_data = 8'h55; bus.tx_ctrl = 2'b00; bus.tx_data_valid = 1'b1;
        frame(8'h55, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        bus.tx_data = 8'h55; bus.tx_ctrl = 2'b01; bus.tx_data_valid = 1'b1;
        frame(8'h55, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        bus.tx_data = 8'h55; bus.tx_ctrl = 2'b11; bus.tx_data_valid = 1'b1;
        frame(8'h55, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        bus.tx_data = 8'hF0; bus.tx_ctrl = 2'b11; bus.tx_data_valid = 1'b1;
        frame(8'hF0, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        bus.tx_data = 8'h07; bus.tx_ctrl = 2'b01; bus.tx_data_valid = 1'b1;
        frame(8'h07, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);

        // 5. Back-to-back
        bus.tx_data = 8'hA3; bus.tx_ctrl = 2'b00; bus.tx_data_valid = 1'b1;
        frame(8'hA3, 2'b00, 1'b0, 1'b1, 8'h3C, 2'b00, 1'b0);
        frame(8'h3C, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);

        // 6. Input changes and stray valid pulses while busy
        bus.tx_data = 8'h96; bus.tx_ctrl = 2'b11; bus.tx_data_valid = 1'b1;
        frame(8'h96, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
        bus.tx_data = 8'h2B; bus.tx_ctrl = 2'b10; bus.tx_data_valid = 1'b1;
        frame(8'h2B, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);

        // Reset in the middle of a frame: immediate return to idle, no resume
        bus.tx_data = 8'hC3; bus.tx_ctrl = 2'b01; bus.tx_data_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_data_valid = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        chk1("busy before rst tx", tx, 1'b0);
        chk1("busy before rst ready", bus.tx_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("async rst tx", tx, 1'b1);
        chk1("async rst ready", bus.tx_ready, 1'b1);
        chk1("async rst done", tx_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int j = 0; j < 120; j++) begin
            @(posedge clk); #1;
            chk1($sformatf("no resume tx cyc%0d", j), tx, 1'b1);
            chk1($sformatf("no resume ready cyc%0d", j), bus.tx_ready, 1'b1);
            chk1($sformatf("no resume done cyc%0d", j), tx_done, 1'b0);
        end

        // Randomized frames, some chained back-to-back
        chained = 1'b0;
        d = 8'($urandom);
        c = 2'($urandom);
        bus.tx_data = d; bus.tx_ctrl = c; bus.tx_data_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chain_out = (i < 9) && ($urandom % 2 == 1);
            nd = 8'($urandom);
            nc = 2'($urandom);
            frame(d, c, chained, chain_out, nd, nc, !chain_out);
            chained = chain_out;
            d = nd;
            c = nc;
            if (!chain_out && i < 9) begin
                bus.tx_data = d; bus.tx_ctrl = c; bus.tx_data_valid = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
